axi_rd_responder: RTL and testbench

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

---
 rtl/axi_rd_pkg.sv | 14 +
 rtl/axi_rd_beat_ctr.sv | 40 ++++
 rtl/axi_rd_responder.sv | 121 ++++++++++++
 tb/tb_axi_rd_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared AXI read-responder types: FSM state encoding and AXI channel widths.
package axi_rd_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } rd_state_t;

endpackage

// File: rtl/axi_rd_beat_ctr.sv
// Beat counter for one read burst: load clears the count and latches the
// burst length, inc advances one beat, last flags the final beat.
module axi_rd_beat_ctr
   import axi_rd_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [AXI_LEN_W-1:0] len_in,
   input  logic                 inc,
   output logic                 last
);

   logic [AXI_LEN_W-1:0] count_q, count_d;
   logic [AXI_LEN_W-1:0] len_q, len_d;

   always_comb begin
      count_d = count_q;
      len_d   = len_q;
      if (load) begin
         count_d = '0;
         len_d   = len_in;
      end else if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         len_q   <= '0;
      end else begin
         count_q <= count_d;
         len_q   <= len_d;
      end
   end

   assign last = (count_q == len_q);

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read-channel responder serving INCR bursts from a backdoor-loaded memory.
// Optional macro AXI_RD_LATENCY_EN inserts a WAIT state of LATENCY cycles.
module axi_rd_responder
   import axi_rd_pkg::*;
#(
   parameter int MEM_AW  = 12,
   parameter int LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AXI_ADDR_W-1:0] araddr,
   input  logic [AXI_LEN_W-1:0]  arlen,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [AXI_DATA_W-1:0] rdata,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic                  init_we,
   input  logic [MEM_AW-1:0]     init_addr,
   input  logic [AXI_DATA_W-1:0] init_data
);

   localparam int DEPTH = 2 ** MEM_AW;

   rd_state_t             state_q, state_d;
   logic [MEM_AW-1:0]     ptr_q, ptr_d;
   logic [AXI_DATA_W-1:0] mem_q [DEPTH];
   logic                  ctr_load;
   logic                  ctr_inc;
   logic                  ctr_last;

   // Only the word index is used; byte offset and high bits alias.
   logic unused_araddr_bits;
   assign unused_araddr_bits = ^{araddr[AXI_ADDR_W-1:MEM_AW+2], araddr[1:0]};

`ifdef AXI_RD_LATENCY_EN
   logic [15:0] wait_q, wait_d;
`else
   localparam int unused_latency = LATENCY;
`endif

   // Backdoor port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (init_we) mem_q[init_addr] <= init_data;
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ctr_load = 1'b0;
      ctr_inc  = 1'b0;
      arready  = 1'b0;
      rvalid   = 1'b0;
`ifdef AXI_RD_LATENCY_EN
      wait_d   = wait_q;
`endif
      case (state_q)
         ST_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               ptr_d    = araddr[MEM_AW+1:2];
               ctr_load = 1'b1;
`ifdef AXI_RD_LATENCY_EN
               wait_d   = 16'(LATENCY - 1);
               state_d  = ST_WAIT;
`else
               state_d  = ST_BURST;
`endif
            end
         end
         ST_WAIT: begin
`ifdef AXI_RD_LATENCY_EN
            if (wait_q == '0) state_d = ST_BURST;
            else              wait_d  = wait_q - 1'b1;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_BURST: begin
            rvalid = 1'b1;
            if (rready) begin
               ctr_inc = 1'b1;
               ptr_d   = ptr_q + 1'b1;
               if (ctr_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
`ifdef AXI_RD_LATENCY_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
`ifdef AXI_RD_LATENCY_EN
         wait_q  <= wait_d;
`endif
      end
   end

   axi_rd_beat_ctr u_beat_ctr (
      .clk    (clk),
      .rst    (rst),
      .load   (ctr_load),
      .len_in (arlen),
      .inc    (ctr_inc),
      .last   (ctr_last)
   );

   // Memory is read combinationally, so rdata follows ptr and stays put under stall.
   assign rdata = mem_q[ptr_q];
   assign rlast = (state_q == ST_BURST) && ctr_last;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: table of bursts over a mem[i]=i image plus
// hand-written sequences for backpressure, backdoor write, and mid-burst reset.
module tb_axi_rd_responder;

   localparam int MEM_AW = 12;
   localparam int DEPTH  = 2 ** MEM_AW;
`ifdef AXI_RD_LATENCY_EN
   localparam int LAT_TICKS = 3;
`else
   localparam int LAT_TICKS = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       araddr;
   logic [7:0]        arlen;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   logic              init_we;
   logic [MEM_AW-1:0] init_addr;
   logic [31:0]       init_data;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   axi_rd_responder #(.MEM_AW(MEM_AW), .LATENCY(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .araddr    (araddr),
      .arlen     (arlen),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   typedef struct {
      logic [31:0]       addr;
      logic [7:0]        len;
      logic [MEM_AW-1:0] first_word;
   } burst_vec_t;

   burst_vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_burst(input logic [31:0] addr, input logic [7:0] len);
      chk("arready_before_ar", {31'b0, arready}, 32'd1);
      araddr  = addr;
      arlen   = len;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      araddr  = '0;
      arlen   = '0;
      for (int i = 0; i < LAT_TICKS; i++) begin
         chk("rvalid_in_wait", {31'b0, rvalid}, 32'd0);
         tick();
      end
   endtask

   // With mem[i]=i, beat k of a burst returns word (first+k) mod DEPTH.
   task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [MEM_AW-1:0] first);
      logic [MEM_AW-1:0] w;
      rready = 1'b1;
      start_burst(addr, len);
      for (int k = 0; k <= int'(len); k++) begin
         w = first + MEM_AW'(k);
         chk("beat_rvalid", {31'b0, rvalid}, 32'd1);
         chk("beat_rdata", rdata, {{(32-MEM_AW){1'b0}}, w});
         chk("beat_rlast", {31'b0, rlast}, {31'b0, (k == int'(len))});
         tick();
      end
      chk("post_burst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("post_burst_arready", {31'b0, arready}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      vecs[0] = '{32'h0000_1040, 8'd7,   12'h410};
      vecs[1] = '{32'h0000_0008, 8'd0,   12'h002};
      vecs[2] = '{32'h0000_3FF8, 8'd3,   12'hFFE};
      vecs[3] = '{32'hABCD_1043, 8'd2,   12'h410};
      vecs[4] = '{32'h0000_7FFC, 8'd1,   12'hFFF};
      vecs[5] = '{32'h0000_0000, 8'd255, 12'h000};
      vecs[6] = '{32'h0000_0014, 8'd0,   12'h005};

      rst = 1'b1; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      init_we = 1'b0; init_addr = '0; init_data = '0;

      // Preload runs while reset is held; memory is not reset.
      for (int i = 0; i < DEPTH; i++) begin
         init_we   = 1'b1;
         init_addr = MEM_AW'(i);
         init_data = 32'(i);
         tick();
      end
      init_we = 1'b0;
      chk("rst_arready", {31'b0, arready}, 32'd1);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_arready", {31'b0, arready}, 32'd1);
      chk("post_rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("post_rst_rlast", {31'b0, rlast}, 32'd0);

      for (int v = 0; v < 7; v++) begin
         run_burst(vecs[v].addr, vecs[v].len, vecs[v].first_word);
         tick();
      end

      // Backpressure: rready 1,0,0 repeating over a 4-beat burst at word 0x40.
      rready = 1'b1;
      start_burst(32'h0000_0100, 8'd3);
      idx = 0;
      for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
         rready = (cyc % 3 == 0);
         chk("bp_rvalid", {31'b0, rvalid}, 32'd1);
         chk("bp_rdata", rdata, 32'h40 + 32'(idx));
         chk("bp_rlast", {31'b0, rlast}, {31'b0, (idx == 3)});
         if (rready) idx++;
         tick();
      end
      chk("bp_beats_taken", 32'(idx), 32'd4);
      chk("bp_done_rvalid", {31'b0, rvalid}, 32'd0);
      rready = 1'b0;
      tick();

      // Backdoor write to the word being presented under stall.
      start_burst(32'h0000_0200, 8'd0);
      chk("bd_old", rdata, 32'h80);
      init_we = 1'b1; init_addr = 12'h080; init_data = 32'hDEAD_BEEF;
      #2;
      chk("bd_same_cycle_old", rdata, 32'h80);
      tick();
      init_we = 1'b0;
      chk("bd_new", rdata, 32'hDEAD_BEEF);
      chk("bd_rlast", {31'b0, rlast}, 32'd1);
      rready = 1'b1;
      tick();
      chk("bd_done_rvalid", {31'b0, rvalid}, 32'd0);
      init_we = 1'b1; init_addr = 12'h080; init_data = 32'h80;
      tick();
      init_we = 1'b0;

      // Reset on beat 3 of an 8-beat burst.
      rready = 1'b1;
      start_burst(32'h0000_1040, 8'd7);
      tick();
      tick();
      chk("mid_rst_beat3", rdata, 32'h412);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("mid_rst_rlast", {31'b0, rlast}, 32'd0);
      chk("mid_rst_arready", {31'b0, arready}, 32'd1);
      tick();
      chk("mid_rst_no_more_beats", {31'b0, rvalid}, 32'd0);
      run_burst(32'h0, 8'd0, 12'h000);
      tick();
      run_burst(32'h0000_0014, 8'd0, 12'h005);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
